// File: rtl/mcpu_exec_stage_if.sv
// Bundle between the execute stage, its instruction source, the external ALU and the debug port.
// The slave side is the stage. The master side is the upstream decoder plus the ALU.
interface mcpu_exec_stage_if #(
  parameter int unsigned WordSize = 16,
  parameter int unsigned CmdSize  = 3,
  parameter int unsigned RegAddr  = 3
) ();

  logic                instr_valid;
  logic                instr_ready;
  logic [CmdSize-1:0]  instr_cmd;
  logic [RegAddr-1:0]  instr_rd;
  logic [RegAddr-1:0]  instr_rs1;
  logic [RegAddr-1:0]  instr_rs2;
  logic                instr_imm_en;
  logic [WordSize-1:0] instr_imm;

  logic [CmdSize-1:0]  alu_cmd;
  logic [WordSize-1:0] alu_in1;
  logic [WordSize-1:0] alu_in2;
  logic [WordSize-1:0] alu_out;
  logic                alu_cf;

  logic                wb_valid;
  logic [RegAddr-1:0]  wb_rd;
  logic                carry;

  logic [RegAddr-1:0]  dbg_addr;
  logic [WordSize-1:0] dbg_data;

  modport master (
    output instr_valid, instr_cmd, instr_rd, instr_rs1, instr_rs2, instr_imm_en, instr_imm,
    output alu_out, alu_cf, dbg_addr,
    input  instr_ready, alu_cmd, alu_in1, alu_in2, wb_valid, wb_rd, carry, dbg_data
  );

  modport slave (
    input  instr_valid, instr_cmd, instr_rd, instr_rs1, instr_rs2, instr_imm_en, instr_imm,
    input  alu_out, alu_cf, dbg_addr,
    output instr_ready, alu_cmd, alu_in1, alu_in2, wb_valid, wb_rd, carry, dbg_data
  );

endinterface

// File: rtl/mcpu_exec_stage.sv
// Execute/writeback sequencer around an external 16-bit ALU: reads operands from an 8-entry
// register file, drives the ALU for two cycles, then writes the result back and keeps carry.
module mcpu_exec_stage #(
  parameter int unsigned WordSize = 16,
  parameter int unsigned CmdSize  = 3,
  parameter int unsigned RegAddr  = 3
) (
  input logic              clk_i,
  input logic              reset_i,
  mcpu_exec_stage_if.slave bus_io
);

  localparam int unsigned NRegs = 2 ** RegAddr;

  typedef enum logic [1:0] {StIdle, StExec, StWait, StWb} state_e;

  state_e              state_q, state_d;
  logic [WordSize-1:0] rf_q [NRegs];
  logic [WordSize-1:0] rf_d [NRegs];
  logic [CmdSize-1:0]  cmd_q, cmd_d;
  logic [RegAddr-1:0]  rd_q, rd_d;
  logic [WordSize-1:0] in1_q, in1_d;
  logic [WordSize-1:0] in2_q, in2_d;
  logic                carry_q, carry_d;

  logic                accept;
  logic                wb_fire;
  logic                carry_cmd;
  logic [WordSize-1:0] rs1_val;
  logic [WordSize-1:0] rs2_val;

  // r0 is hardwired to zero on every read path.
  function automatic logic [WordSize-1:0] read_reg(input logic [RegAddr-1:0] addr,
                                                   input logic [WordSize-1:0] val);
    return (addr == '0) ? '0 : val;
  endfunction

  assign accept    = (state_q == StIdle) && bus_io.instr_valid;
  assign wb_fire   = (state_q == StWb);
  assign carry_cmd = (cmd_q == CmdSize'(3)) || (cmd_q == CmdSize'(6)) ||
                     (cmd_q == CmdSize'(7));
  assign rs1_val   = read_reg(bus_io.instr_rs1, rf_q[bus_io.instr_rs1]);
  assign rs2_val   = read_reg(bus_io.instr_rs2, rf_q[bus_io.instr_rs2]);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StExec;
      StExec: state_d = StWait;
      StWait: state_d = StWb;
      StWb:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus_io.instr_ready = 1'b0;
    bus_io.wb_valid    = 1'b0;
    unique case (state_q)
      StIdle: bus_io.instr_ready = 1'b1;
      StWb:   bus_io.wb_valid    = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand capture and writeback next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd_d   = cmd_q;
    rd_d    = rd_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    carry_d = carry_q;
    rf_d    = rf_q;

    if (accept) begin
      cmd_d = bus_io.instr_cmd;
      rd_d  = bus_io.instr_rd;
      in1_d = rs1_val;
      in2_d = bus_io.instr_imm_en ? bus_io.instr_imm : rs2_val;
    end

    if (wb_fire) begin
      if (rd_q != '0) begin
        rf_d[rd_q] = bus_io.alu_out;
      end
      if (carry_cmd) begin
        carry_d = bus_io.alu_cf;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cmd_q   <= '0;
      rd_q    <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      carry_q <= 1'b0;
      for (int i = 0; i < NRegs; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      cmd_q   <= cmd_d;
      rd_q    <= rd_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      carry_q <= carry_d;
      rf_q    <= rf_d;
    end
  end

  assign bus_io.alu_cmd  = cmd_q;
  assign bus_io.alu_in1  = in1_q;
  assign bus_io.alu_in2  = in2_q;
  assign bus_io.wb_rd    = rd_q;
  assign bus_io.carry    = carry_q;
  assign bus_io.dbg_data = read_reg(bus_io.dbg_addr, rf_q[bus_io.dbg_addr]);

endmodule
